program_loader: RTL

//  Boot-time writer for the instruction memory that the RISC core reads during fetch.

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader_word_assembler.sv | 39 +++
 rtl/program_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic accepts_byte(state_t s);
        return s inside {HDR_LO, HDR_HI, DATA, CHK};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit instruction word.
module loader_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = accept_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: header word count, then little-endian words written to imem; holds cpu_reset until loaded.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
//
//  state  | meaning
//  IDLE   | one cycle after reset, then header
//  HDR_LO | waiting for count[7:0]
//  HDR_HI | waiting for count[15:8], decides DONE/ERROR/DATA
//  DATA   | collecting the four bytes of the next word
//  WRITE  | one-cycle imem write strobe
//  CHK    | waiting for the checksum byte (checksum build only)
//  DONE   | image loaded, core released
//  ERROR  | load aborted, core held
module program_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    program_loader_if.slave    bus,
    output logic               cpu_reset,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] words_loaded
);
    localparam int HDR_BITS = 8 * HDR_BYTES;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t               state_q, state_d;
    logic [7:0]           cnt_lo_q, cnt_lo_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   words_q, words_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    logic                 xfer;
    logic                 rearm;
    logic                 asm_accept;
    logic                 asm_clear;
    logic                 word_full;
    logic [31:0]          asm_word;
    logic [HDR_BITS-1:0]  hdr_count;

    assign bus.in_ready = accepts_byte(state_q);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign asm_accept   = xfer && (state_q == DATA);
    assign hdr_count    = {bus.in_data, cnt_lo_q};
    assign rearm        = start && ((state_q == DONE) || (state_q == ERROR));

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .accept_i   (asm_accept),
        .byte_i     (bus.in_data),
        .clear_i    (asm_clear),
        .word_o     (asm_word),
        .word_full_o(word_full)
    );

    // The word index and words_loaded always advance together, so one counter serves both.
    assign bus.imem_we    = (state_q == WRITE);
    assign bus.imem_addr  = BASE_ADDR + ADDR_W'(words_q) * ADDR_W'(BYTES_PER_WORD);
    assign bus.imem_wdata = (state_q == WRITE) ? asm_word : '0;

    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        count_d     = count_q;
        words_d     = words_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        asm_clear   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: state_d = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    cnt_lo_d = bus.in_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    count_d = hdr_count;
                    if (hdr_count == '0)
                        state_d = AFTER_DATA;
                    else if (32'(hdr_count) > 32'(MAX_WORDS))
                        state_d = ERROR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (xfer)
                    csum_d = csum_q ^ bus.in_data;
`endif
                if (word_full)
                    state_d = WRITE;
            end
            WRITE: begin
                words_d = words_q + COUNT_W'(1);
                state_d = (words_d == count_q) ? AFTER_DATA : DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer)
                    state_d = (bus.in_data == csum_q) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
            end
            ERROR: begin
                err_d       = 1'b1;
                done_d      = 1'b0;
                cpu_reset_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (rearm) begin
            state_d     = HDR_LO;
            words_d     = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            cpu_reset_d = 1'b1;
            asm_clear   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_lo_q    <= '0;
            count_q     <= '0;
            words_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            words_q     <= words_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
